mt32_audio_sink: RTL and testbench
==================================

Name: mt32_audio_sink

Overview:
- Stage directly downstream of the MT32-pi I2S deserializer. Consumes its per-channel word strobes, which arrive left-then-right.
- Assembles each left/right pair into a stereo frame and applies a click-free gain fade. Mutes on loss of signal.
- Drives the core's AUDIO_L/AUDIO_R (signed) in the CLK_AUDIO domain.

Parameters:
- TIMEOUT, 24576: CLK_AUDIO cycles without a committed frame before the input is declared dead (1 ms at 24.576 MHz).
- DROP_W, 8: width of the saturating dropped-word counter.

Ports:
- CLK_AUDIO  in  1  sole clock (24.576 MHz audio clock).
- RESET  in  1  asynchronous, active-high reset.
- l_valid  in  1  single-cycle strobe: l_data holds a new left word.
- l_data  in  16  signed left sample.
- r_valid  in  1  single-cycle strobe: r_data holds a new right word.
- r_data  in  16  signed right sample.
- gain  in  9  target gain in Q1.8 (256 = unity). Values >256 clamp to 256.
- mute  in  1  level; 1 fades the output to zero.
- AUDIO_L  out  16  signed left output.
- AUDIO_R  out  16  signed right output.
- frame_strobe  out  1  one-cycle pulse when AUDIO_L/R update.
- active  out  1  1 while frames arrive within TIMEOUT.
- dropped  out  DROP_W  saturating count of orphaned/overwritten words.

Behaviour:
- Reset values: AUDIO_L=AUDIO_R=0, frame_strobe=0, active=0, dropped=0, fader=0, FSM=WAIT_L, timeout counter=0.
- Reset is asynchronous on assertion and released synchronously. Reset mid-frame discards the pending left word.
- Pairing FSM, states WAIT_L and WAIT_R:
  - WAIT_L + l_valid: latch left, go to WAIT_R.
  - WAIT_L + r_valid alone: ignore the word, dropped++.
  - WAIT_L + l_valid and r_valid in the same cycle: latch both, commit, stay in WAIT_L.
  - WAIT_R + r_valid: latch right, commit, go to WAIT_L.
  - WAIT_R + l_valid: overwrite the pending left, dropped++, stay in WAIT_R.
  - WAIT_R + l_valid and r_valid in the same cycle: commit the pending left with the new right, then latch the new left, stay in WAIT_R.
- dropped saturates at all-ones and never wraps.
- Fader (9-bit):
  - Target = (mute | ~active) ? 0 : min(gain, 256).
  - On each commit the fader moves one step (±1) toward the target, before the multiply of that frame. It holds when equal to the target.
  - A full fade 0↔256 takes 256 frames.
- Arithmetic pipeline, 2 stages:
  - Stage 1 (cycle after commit): product = sample × fader, signed 16 × unsigned 9 → 25 bits.
  - Stage 2: result = product >>> 8 (arithmetic shift, floor), saturated to [-32768, 32767]. The result registers into AUDIO_L/AUDIO_R together. frame_strobe pulses in the same cycle.
  - Latency: commit cycle + 2 cycles to the output update.
  - Unity gain is bit-exact: result = sample.
- Back-to-back commits every cycle are sustained, since the pipeline is fully pipelined.
- Timeout:
  - The counter clears on each commit and otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT: active←0, fader←0, and AUDIO_L/AUDIO_R←0 immediately. No frame_strobe is issued. The FSM returns to WAIT_L.
  - The next commit sets active←1. That frame is output with fader=0 (output 0), then the fader ramps up from 0 one step per frame.
- gain/mute changes mid-fade retarget immediately; the ramp continues from the current fader value.

Decomposition:
- Package mt32_audio_pkg holds:
  - typedef sample_t (logic signed [15:0]);
  - localparam UNITY = 9'd256;
  - enum pair_state_t {WAIT_L, WAIT_R}.
- One sub-module, mt32_gain_stage: 2-stage multiply/shift/saturate for one channel, instantiated twice. It takes sample, fader and valid, and returns result and valid.

Test Plan:
- Reset, then gain=256, mute=0; send L=0x1234 then R=-5 (0xFFFB) → active=1; first frame outputs 0/0; after 256 frames outputs are exactly 0x1234/0xFFFB, with frame_strobe 2 cycles after each r_valid.
- Fader settled at 128; send L=-3, R=3 → AUDIO_L=-2 (floor), AUDIO_R=1.
- Two l_valid (0x0100, then 0x0200) before r_valid=0x0300 at unity → output L=0x0200, R=0x0300, dropped=1. A lone r_valid in WAIT_L → dropped=2, no strobe.
- Settled at unity, stop all strobes for 24576 cycles → active falls and AUDIO_L/R=0 on that cycle. Resume frames → output ramps back up by 1/256 per frame.
- mute=1 at unity → fader decreases by 1 per frame and reaches 0 after 256 frames. Release mute at fader 100 → ramps up from 100.
- Assert RESET while in WAIT_R → all outputs 0 asynchronously. After release, a lone r_valid is counted as dropped (dropped=1).

Source files
------------

// File: rtl/mt32_audio_pkg.sv
// MT32 audio sink shared types.
// Sample type, unity gain and pairing states.
package mt32_audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam logic [8:0] UNITY = 9'd256;

  typedef enum logic {
    WAIT_L,
    WAIT_R
  } pair_state_t;

endpackage

// File: rtl/mt32_audio_sink_if.sv
// Per-channel word strobes from the I2S deserializer.
// Left word is expected before right word.
interface mt32_audio_sink_if;
  import mt32_audio_pkg::*;

  logic    l_valid;
  sample_t l_data;
  logic    r_valid;
  sample_t r_data;

  modport master (
    output l_valid,
    output l_data,
    output r_valid,
    output r_data
  );

  modport slave (
    input l_valid,
    input l_data,
    input r_valid,
    input r_data
  );

endinterface

// File: rtl/mt32_gain_stage.sv
// One channel of fader gain: multiply, then shift and saturate.
// Two register stages; flush kills in-flight data and zeroes result.
module mt32_gain_stage
  import mt32_audio_pkg::*;
(
  input  logic       CLK_AUDIO,
  input  logic       RESET,
  input  logic       flush,
  input  logic       valid,
  input  sample_t    sample,
  input  logic [8:0] fader,
  output logic       result_valid,
  output sample_t    result
);

  logic signed [24:0] full;
  logic signed [24:0] prod;
  logic signed [16:0] shifted;
  logic               prod_valid;
  sample_t            sat;

  assign full    = 25'(sample) * 25'($signed({1'b0, fader}));
  assign shifted = 17'(prod >>> 8);

  // Clamp the floored product into the 16-bit sample range.
  always_comb begin
    sat = shifted[15:0];
    if (shifted[16] != shifted[15]) begin
      sat = shifted[16] ? 16'sh8000 : 16'sh7fff;
    end
  end

  // Product register, then result register.
  always_ff @(posedge CLK_AUDIO or posedge RESET) begin
    if (RESET) begin
      prod_valid   <= 1'b0;
      prod         <= '0;
      result_valid <= 1'b0;
      result       <= '0;
    end else if (flush) begin
      prod_valid   <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      prod_valid   <= valid;
      result_valid <= prod_valid;
      if (valid) prod <= full;
      if (prod_valid) result <= sat;
    end
  end

endmodule

// File: rtl/mt32_audio_sink.sv
// Pairs I2S left/right words into frames, fades gain, mutes on loss.
// Output lands two cycles after the committing right word.
module mt32_audio_sink
  import mt32_audio_pkg::*;
#(
  parameter int TIMEOUT = 24576,
  parameter int DROP_W  = 8
) (
  input  logic              CLK_AUDIO,
  input  logic              RESET,
  mt32_audio_sink_if.slave  wd,
  input  logic [8:0]        gain,
  input  logic              mute,
  output sample_t           AUDIO_L,
  output sample_t           AUDIO_R,
  output logic              frame_strobe,
  output logic              active,
  output logic [DROP_W-1:0] dropped
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_HIT = TW'(TIMEOUT - 1);

  pair_state_t   state;
  sample_t       left_q;
  sample_t       c_left;
  logic          commit;
  logic          drop;
  logic          to_hit;
  logic [8:0]    fader;
  logic [8:0]    target;
  logic [8:0]    fader_nx;
  logic [TW-1:0] tcnt;
  logic          l_done;
  logic          r_done;

  // Decide whether this cycle commits a frame or orphans a word.
  always_comb begin
    commit = 1'b0;
    drop   = 1'b0;
    c_left = left_q;
    unique case (state)
      WAIT_L: begin
        commit = wd.l_valid & wd.r_valid;
        drop   = wd.r_valid & ~wd.l_valid;
        c_left = wd.l_data;
      end
      WAIT_R: begin
        commit = wd.r_valid;
        drop   = wd.l_valid & ~wd.r_valid;
      end
      default: ;
    endcase
  end

  assign to_hit = ~commit & (tcnt == TO_HIT);

  // One fader step toward the target, taken on each commit.
  always_comb begin
    target = (mute | ~active) ? 9'd0 : ((gain > UNITY) ? UNITY : gain);
    unique case (1'b1)
      fader < target: fader_nx = fader + 9'd1;
      fader > target: fader_nx = fader - 9'd1;
      default:        fader_nx = fader;
    endcase
  end

  // Pairing FSM; a dead link abandons any half-built frame.
  always_ff @(posedge CLK_AUDIO or posedge RESET) begin
    if (RESET) begin
      state  <= WAIT_L;
      left_q <= '0;
    end else if (to_hit) begin
      state <= WAIT_L;
    end else begin
      unique case (state)
        WAIT_L: begin
          if (wd.l_valid && !wd.r_valid) begin
            left_q <= wd.l_data;
            state  <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (wd.l_valid) begin
            left_q <= wd.l_data;
          end else if (wd.r_valid) begin
            state <= WAIT_L;
          end
        end
        default: state <= WAIT_L;
      endcase
    end
  end

  // Fader, link supervision and dropped-word count.
  always_ff @(posedge CLK_AUDIO or posedge RESET) begin
    if (RESET) begin
      fader   <= '0;
      active  <= 1'b0;
      tcnt    <= '0;
      dropped <= '0;
    end else begin
      if (drop && (dropped != '1)) begin
        dropped <= dropped + DROP_W'(1);
      end
      if (commit) begin
        fader  <= fader_nx;
        active <= 1'b1;
        tcnt   <= '0;
      end else if (tcnt != TO_MAX) begin
        tcnt <= tcnt + TW'(1);
        if (to_hit) begin
          active <= 1'b0;
          fader  <= '0;
        end
      end
    end
  end

  mt32_gain_stage u_gain_l (
    .CLK_AUDIO    (CLK_AUDIO),
    .RESET        (RESET),
    .flush        (to_hit),
    .valid        (commit),
    .sample       (c_left),
    .fader        (fader_nx),
    .result_valid (l_done),
    .result       (AUDIO_L)
  );

  mt32_gain_stage u_gain_r (
    .CLK_AUDIO    (CLK_AUDIO),
    .RESET        (RESET),
    .flush        (to_hit),
    .valid        (commit),
    .sample       (wd.r_data),
    .fader        (fader_nx),
    .result_valid (r_done),
    .result       (AUDIO_R)
  );

  assign frame_strobe = l_done & r_done;

endmodule

// File: tb/tb_mt32_audio_sink.sv
// Bench for mt32_audio_sink: random frames vs a frame-level model.
// Covers pairing, fading, timeout, mute and async reset.
module tb_mt32_audio_sink;
  import mt32_audio_pkg::*;

  localparam int TO = 24576;

  logic       CLK_AUDIO = 1'b0;
  logic       RESET = 1'b1;
  logic [8:0] gain = 9'd0;
  logic       mute = 1'b0;
  sample_t    AUDIO_L;
  sample_t    AUDIO_R;
  logic       frame_strobe;
  logic       active;
  logic [7:0] dropped;

  mt32_audio_sink_if wd ();

  mt32_audio_sink #(
    .TIMEOUT (TO),
    .DROP_W  (8)
  ) dut (
    .CLK_AUDIO    (CLK_AUDIO),
    .RESET        (RESET),
    .wd           (wd),
    .gain         (gain),
    .mute         (mute),
    .AUDIO_L      (AUDIO_L),
    .AUDIO_R      (AUDIO_R),
    .frame_strobe (frame_strobe),
    .active       (active),
    .dropped      (dropped)
  );

  always #5 CLK_AUDIO = ~CLK_AUDIO;

  int cyc = 0;
  always @(posedge CLK_AUDIO) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  int   m_fader = 0;
  int   m_dropped = 0;
  bit   m_active = 1'b0;
  int   last_rc = 0;
  logic o_s;
  int   o_l;
  int   o_r;

  function automatic int rnd_s();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  // floor(s * f / 256)
  function automatic int scale(input int s, input int f);
    int p;
    p = s * f;
    if (p >= 0) return p / 256;
    return -((-p + 255) / 256);
  endfunction

  task automatic model_commit(input int l, input int r,
                              output int el, output int er);
    int tgt;
    tgt = (mute || !m_active) ? 0 : ((int'(gain) > 256) ? 256 : int'(gain));
    if (m_fader < tgt) m_fader++;
    else if (m_fader > tgt) m_fader--;
    m_active = 1'b1;
    el = scale(l, m_fader);
    er = scale(r, m_fader);
  endtask

  task automatic tick(input logic lv, input int ld,
                      input logic rv, input int rd);
    wd.l_valid = lv;
    wd.l_data  = 16'(ld);
    wd.r_valid = rv;
    wd.r_data  = 16'(rd);
    if (rv) last_rc = cyc;
    @(posedge CLK_AUDIO);
    #1;
    wd.l_valid = 1'b0;
    wd.r_valid = 1'b0;
    o_s = frame_strobe;
    o_l = AUDIO_L;
    o_r = AUDIO_R;
  endtask

  // L cycle, R cycle, idle; leaves o_* at the output cycle.
  task automatic send_frame(input int l, input int r, output logic s1);
    tick(1'b1, l, 1'b0, 0);
    tick(1'b0, 0, 1'b1, r);
    s1 = o_s;
    tick(1'b0, 0, 1'b0, 0);
  endtask

  task automatic settle_unity();
    int   l, r, el, er, n;
    logic s1;
    gain = 9'd256;
    mute = 1'b0;
    n = 0;
    while ((m_fader != 256 || !m_active) && n < 600) begin
      l = rnd_s();
      r = rnd_s();
      send_frame(l, r, s1);
      model_commit(l, r, el, er);
      n++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK_AUDIO);
    #1;
    checks++;
    if (AUDIO_L !== 16'sd0 || AUDIO_R !== 16'sd0) begin
      errors++;
      $display("FAIL reset_audio got %0d/%0d want 0/0", AUDIO_L, AUDIO_R);
    end
    checks++;
    if (active !== 1'b0 || frame_strobe !== 1'b0 || dropped !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags got act=%b fs=%b drop=%0d want 0/0/0",
               active, frame_strobe, dropped);
    end
    RESET = 1'b0;
  endtask

  task automatic test_ramp_up();
    int   el, er;
    logic s1;
    gain = 9'd256;
    mute = 1'b0;
    send_frame('h1234, -5, s1);
    model_commit('h1234, -5, el, er);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL ramp_active got %b want 1", active);
    end
    checks++;
    if (o_l !== 0 || o_r !== 0 || s1 !== 1'b0 || o_s !== 1'b1) begin
      errors++;
      $display("FAIL ramp_first got %0d/%0d fs=%b%b want 0/0 fs=01",
               o_l, o_r, s1, o_s);
    end
    for (int i = 0; i < 256; i++) begin
      send_frame('h1234, -5, s1);
      model_commit('h1234, -5, el, er);
      checks++;
      if (s1 !== 1'b0 || o_s !== 1'b1 || o_l !== el || o_r !== er) begin
        errors++;
        $display("FAIL ramp_frame%0d got %0d/%0d fs=%b%b want %0d/%0d fs=01",
                 i, o_l, o_r, s1, o_s, el, er);
      end
    end
    checks++;
    if (o_l !== 'h1234 || o_r !== -5) begin
      errors++;
      $display("FAIL ramp_unity got %0d/%0d want 4660/-5", o_l, o_r);
    end
  endtask

  task automatic test_half_gain();
    int   l, r, el, er;
    logic s1;
    gain = 9'd128;
    for (int i = 0; i < 128; i++) begin
      l = rnd_s();
      r = rnd_s();
      send_frame(l, r, s1);
      model_commit(l, r, el, er);
      checks++;
      if (o_s !== 1'b1 || o_l !== el || o_r !== er) begin
        errors++;
        $display("FAIL fade_down%0d got %0d/%0d want %0d/%0d",
                 i, o_l, o_r, el, er);
      end
    end
    send_frame(-3, 3, s1);
    model_commit(-3, 3, el, er);
    checks++;
    if (o_l !== -2 || o_r !== 1) begin
      errors++;
      $display("FAIL half_floor got %0d/%0d want -2/1", o_l, o_r);
    end
  endtask

  task automatic test_pairing();
    int   el, er;
    logic s1;
    settle_unity();
    tick(1'b1, 'h0100, 1'b0, 0);
    tick(1'b1, 'h0200, 1'b0, 0);
    m_dropped++;
    tick(1'b0, 0, 1'b1, 'h0300);
    s1 = o_s;
    tick(1'b0, 0, 1'b0, 0);
    model_commit('h0200, 'h0300, el, er);
    checks++;
    if (s1 !== 1'b0 || o_s !== 1'b1 || o_l !== 'h0200 || o_r !== 'h0300) begin
      errors++;
      $display("FAIL overwrite got %0d/%0d fs=%b%b want 512/768 fs=01",
               o_l, o_r, s1, o_s);
    end
    checks++;
    if (int'(dropped) !== m_dropped) begin
      errors++;
      $display("FAIL drop_overwrite got %0d want %0d", dropped, m_dropped);
    end
    tick(1'b0, 0, 1'b1, rnd_s());
    m_dropped++;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 0, 1'b0, 0);
      checks++;
      if (o_s !== 1'b0) begin
        errors++;
        $display("FAIL orphan_strobe%0d got %b want 0", i, o_s);
      end
    end
    checks++;
    if (int'(dropped) !== m_dropped) begin
      errors++;
      $display("FAIL drop_orphan got %0d want %0d", dropped, m_dropped);
    end
  endtask

  task automatic test_same_cycle();
    int a, b, c, d, e, f;
    int ea, eb, ec, ee, edd, ef;
    a = rnd_s(); b = rnd_s(); c = rnd_s();
    d = rnd_s(); e = rnd_s(); f = rnd_s();
    model_commit(a, b, ea, eb);
    tick(1'b1, a, 1'b1, b);
    tick(1'b1, c, 1'b0, 0);
    checks++;
    if (o_s !== 1'b1 || o_l !== ea || o_r !== eb) begin
      errors++;
      $display("FAIL both_wait_l got %0d/%0d fs=%b want %0d/%0d",
               o_l, o_r, o_s, ea, eb);
    end
    model_commit(c, e, ec, ee);
    tick(1'b1, d, 1'b1, e);
    checks++;
    if (o_s !== 1'b0) begin
      errors++;
      $display("FAIL both_gap got fs=%b want 0", o_s);
    end
    model_commit(d, f, edd, ef);
    tick(1'b0, 0, 1'b1, f);
    checks++;
    if (o_s !== 1'b1 || o_l !== ec || o_r !== ee) begin
      errors++;
      $display("FAIL both_wait_r got %0d/%0d fs=%b want %0d/%0d",
               o_l, o_r, o_s, ec, ee);
    end
    tick(1'b0, 0, 1'b0, 0);
    checks++;
    if (o_s !== 1'b1 || o_l !== edd || o_r !== ef) begin
      errors++;
      $display("FAIL both_pending got %0d/%0d fs=%b want %0d/%0d",
               o_l, o_r, o_s, edd, ef);
    end
  endtask

  task automatic test_back_to_back();
    int el_q[$];
    int er_q[$];
    int l, r, el, er;
    gain = 9'($urandom_range(200, 300));
    for (int k = 0; k <= 24; k++) begin
      if (k < 24) begin
        mute = ($urandom_range(3) == 0);
        l = rnd_s();
        r = rnd_s();
        model_commit(l, r, el, er);
        el_q.push_back(el);
        er_q.push_back(er);
        tick(1'b1, l, 1'b1, r);
      end else begin
        tick(1'b0, 0, 1'b0, 0);
      end
      if (k >= 1) begin
        checks++;
        if (o_s !== 1'b1 || o_l !== el_q[0] || o_r !== er_q[0]) begin
          errors++;
          $display("FAIL b2b%0d got %0d/%0d fs=%b want %0d/%0d",
                   k - 1, o_l, o_r, o_s, el_q[0], er_q[0]);
        end
        void'(el_q.pop_front());
        void'(er_q.pop_front());
      end
    end
    mute = 1'b0;
  endtask

  task automatic test_timeout();
    int   el, er, tgt;
    logic s1;
    settle_unity();
    send_frame('h2000, -'h2000, s1);
    model_commit('h2000, -'h2000, el, er);
    tgt = last_rc + TO;
    while (cyc < tgt) begin
      @(posedge CLK_AUDIO);
      #1;
    end
    checks++;
    if (active !== 1'b1 || int'(AUDIO_L) !== el || int'(AUDIO_R) !== er) begin
      errors++;
      $display("FAIL pre_timeout got act=%b %0d/%0d want 1 %0d/%0d",
               active, AUDIO_L, AUDIO_R, el, er);
    end
    @(posedge CLK_AUDIO);
    #1;
    checks++;
    if (active !== 1'b0 || AUDIO_L !== 16'sd0 || AUDIO_R !== 16'sd0 ||
        frame_strobe !== 1'b0) begin
      errors++;
      $display("FAIL timeout got act=%b %0d/%0d fs=%b want 0 0/0 fs=0",
               active, AUDIO_L, AUDIO_R, frame_strobe);
    end
    m_active = 1'b0;
    m_fader  = 0;
    for (int i = 0; i < 10; i++) begin
      send_frame('h4000, -'h4000, s1);
      model_commit('h4000, -'h4000, el, er);
      checks++;
      if (o_s !== 1'b1 || o_l !== el || o_r !== er) begin
        errors++;
        $display("FAIL resume%0d got %0d/%0d want %0d/%0d",
                 i, o_l, o_r, el, er);
      end
      if (i == 1) begin
        checks++;
        if (o_l !== 64 || o_r !== -64) begin
          errors++;
          $display("FAIL resume_step got %0d/%0d want 64/-64", o_l, o_r);
        end
      end
    end
  endtask

  task automatic test_mute();
    int   l, r, el, er;
    logic s1;
    settle_unity();
    mute = 1'b1;
    for (int i = 0; i < 156; i++) begin
      l = rnd_s();
      r = rnd_s();
      send_frame(l, r, s1);
      model_commit(l, r, el, er);
      checks++;
      if (o_s !== 1'b1 || o_l !== el || o_r !== er) begin
        errors++;
        $display("FAIL mute_fade%0d got %0d/%0d want %0d/%0d",
                 i, o_l, o_r, el, er);
      end
    end
    mute = 1'b0;
    send_frame('h0100, -'h0100, s1);
    model_commit('h0100, -'h0100, el, er);
    checks++;
    if (o_l !== 101 || o_r !== -101) begin
      errors++;
      $display("FAIL unmute_101 got %0d/%0d want 101/-101", o_l, o_r);
    end
    settle_unity();
    mute = 1'b1;
    for (int i = 0; i < 256; i++) begin
      l = (i == 255) ? 32767 : rnd_s();
      r = (i == 255) ? -32768 : rnd_s();
      send_frame(l, r, s1);
      model_commit(l, r, el, er);
      checks++;
      if (o_l !== el || o_r !== er) begin
        errors++;
        $display("FAIL mute_full%0d got %0d/%0d want %0d/%0d",
                 i, o_l, o_r, el, er);
      end
    end
    checks++;
    if (o_l !== 0 || o_r !== 0) begin
      errors++;
      $display("FAIL mute_zero got %0d/%0d want 0/0", o_l, o_r);
    end
    mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    settle_unity();
    tick(1'b1, 'h1111, 1'b0, 0);
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if (AUDIO_L !== 16'sd0 || AUDIO_R !== 16'sd0 || active !== 1'b0 ||
        dropped !== 8'd0 || frame_strobe !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %0d/%0d act=%b drop=%0d fs=%b want 0",
               AUDIO_L, AUDIO_R, active, dropped, frame_strobe);
    end
    @(posedge CLK_AUDIO);
    #1;
    RESET     = 1'b0;
    m_fader   = 0;
    m_active  = 1'b0;
    m_dropped = 0;
    tick(1'b0, 0, 1'b1, 'h2222);
    m_dropped++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_s !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_strobe%0d got %b want 0", i, o_s);
      end
      tick(1'b0, 0, 1'b0, 0);
    end
    checks++;
    if (int'(dropped) !== m_dropped) begin
      errors++;
      $display("FAIL post_reset_drop got %0d want %0d", dropped, m_dropped);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    wd.l_valid = 1'b0;
    wd.l_data  = '0;
    wd.r_valid = 1'b0;
    wd.r_data  = '0;
    test_reset();
    test_ramp_up();
    test_half_gain();
    test_pairing();
    test_same_cycle();
    test_back_to_back();
    test_timeout();
    test_mute();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
